boreal_classifier_cfg_sequencer: RTL and testbench
==================================================

// Module: boreal_classifier_cfg_sequencer
// PURPOSE
//  Owns the weight/bias register port of the BCI click classifier. Host writes land in a
//  5-entry shadow bank (w0..w3, bias). A commit snapshots the bank and streams it into the
//  classifier as 5 back-to-back register writes, so the weights update atomically. Sample
//  valids are gated off for the whole sequence and every dropped sample is counted.
//  Sits between the host CSR decoder and the classifier, on the valid path to the classifier.
// PARAMETERS
//  NREG         5   registers per commit; addr 0..3 = w0..w3, addr 4 = bias
//  QUIET_CYCLES 2   consecutive in_valid=0 cycles needed before the sequence starts (>=1)
//  TIMEOUT      64  max WAIT_QUIET cycles before the sequence is forced (>=QUIET_CYCLES)
//  DROP_W       8   drop counter width
// PORTS
//  clk        in   1       clock
//  rst        in   1       async reset, active-high
//  host_addr  in   3       shadow index
//  host_din   in   16      shadow data, signed Q-format as consumed by the classifier
//  host_we    in   1       shadow write strobe; writes with addr>=NREG are ignored
//  commit     in   1       single-cycle commit request
//  in_valid   in   1       sample valid from the decoder
//  out_valid  out  1       in_valid & ~hold, combinational; drives the classifier valid
//  cfg_addr   out  3       classifier reg_addr
//  cfg_din    out  16      classifier reg_din
//  cfg_we     out  1       classifier reg_we
//  hold       out  1       registered; high in WRITE and RELEASE
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse in RELEASE
//  drop_clr   in   1       synchronous clear of drop_cnt
//  drop_cnt   out  DROP_W  saturating count of in_valid cycles while hold=1
// BEHAVIOUR
//  Reset: shadow and staging w0..w3 = 0 and bias = 16'hC000, matching the classifier reset
//   values. State = IDLE; cfg_we, hold, done and pending = 0; drop_cnt = 0; cfg_addr/cfg_din = 0.
//  A reset mid-sequence aborts the sequence. Later committed registers keep their old values,
//   and the host must re-commit.
//  Shadow: on host_we with a valid addr, the write lands at the next edge, in any state.
//  Snapshot: staging <= shadow when a commit is accepted. A host_we in the same cycle as the
//   commit is included in the snapshot (bypass). Later host writes never affect an
//   in-flight sequence.
//  FSM:
//   IDLE -> WAIT_QUIET on commit. Snapshot taken; quiet_cnt = 0; wait_cnt = 0.
//   WAIT_QUIET: wait_cnt++ every cycle. quiet_cnt++ when in_valid=0, else quiet_cnt = 0.
//    -> WRITE when (in_valid=0 && quiet_cnt == QUIET_CYCLES-1) or wait_cnt == TIMEOUT-1.
//   WRITE: idx runs 0..NREG-1, one cycle each, with cfg_we=1, cfg_addr=idx, cfg_din=staging[idx].
//    cfg_* outputs are registered, so the first write appears the cycle WRITE is entered.
//    -> RELEASE after idx = NREG-1.
//   RELEASE: one cycle; cfg_we=0; done=1; hold still 1, which absorbs the classifier's
//    1-cycle sum pipeline.
//    -> WAIT_QUIET if pending (clears pending and snapshots the shadow now), else IDLE.
//  Commit while busy: sets pending. Extra commits while pending is already set merge into it.
//  Commit in the same cycle as RELEASE: counts as pending.
//  Latency: commit at cycle t with a quiet line and QUIET_CYCLES=2 -> first cfg_we at t+3,
//   done at t+3+NREG.
//  drop_cnt increments when in_valid && hold, and saturates at all-ones.
//   drop_clr wins over an increment in the same cycle.
//  out_valid is never high while hold=1.
//  cfg_we is never high outside WRITE.
// STRUCTURE
//  Shared package boreal_pkg: NREG, CFG_ADDR_W=3, CFG_DATA_W=16, BIAS_RST=16'hC000,
//   and the FSM state encoding (IDLE, WAIT_QUIET, WRITE, RELEASE).
//  Single module with no sub-module; the shadow and staging banks are flat 5x16 register arrays.
// TESTING
//  1 Reset, then commit with no host writes, in_valid=0 -> cfg writes (0,0),(1,0),(2,0),(3,0),(4,C000);
//    done at t+8.
//  2 Host writes w1=0x0123, bias=0xF000, then commit -> exactly 5 cfg_we cycles; addr1=0123, addr4=F000.
//  3 in_valid toggling 1,0,1,0... after commit -> sequence starts only after 2 consecutive zeros.
//  4 in_valid held at 1 -> forced start at wait_cnt=63; drop_cnt=6 (WRITE+RELEASE); out_valid low throughout.
//  5 Commit, then host_we w0=0x7FFF during WRITE, then a second commit -> first pass writes the old w0,
//    pending re-runs with w0=7FFF; two done pulses.
//  6 Assert rst during WRITE at idx=2 -> all outputs at reset values on the next cycle;
//    no further cfg_we; the next commit restarts from idx 0.

Source files
------------

// File: rtl/boreal_classifier_cfg_sequencer_pkg.sv
// boreal_pkg: shared constants and FSM encoding for the classifier config sequencer
package boreal_pkg;
  localparam int NREG = 5;
  localparam int CFG_ADDR_W = 3;
  localparam int CFG_DATA_W = 16;
  localparam logic [CFG_DATA_W-1:0] BIAS_RST = 16'hC000;
  typedef enum logic [1:0] {IDLE, WAIT_QUIET, WRITE, RELEASE} state_t;
  function automatic logic [CFG_DATA_W-1:0] reg_rst(input int i);
    return i == NREG - 1 ? BIAS_RST : '0;
  endfunction
endpackage

// File: rtl/boreal_classifier_cfg_sequencer_if.sv
// boreal_classifier_cfg_sequencer_if: register write bus (addr/data/strobe)
interface boreal_classifier_cfg_sequencer_if;
  import boreal_pkg::*;
  logic [CFG_ADDR_W-1:0] addr;
  logic [CFG_DATA_W-1:0] din;
  logic                  we;
  modport master(output addr, din, we);
  modport slave(input addr, din, we);
endinterface

// File: rtl/boreal_classifier_cfg_sequencer.sv
// boreal_classifier_cfg_sequencer: shadows host weight writes and streams them atomically into the classifier
module boreal_classifier_cfg_sequencer
  import boreal_pkg::*;
#(
  parameter int QUIET_CYCLES = 2,
  parameter int TIMEOUT      = 64,
  parameter int DROP_W       = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  boreal_classifier_cfg_sequencer_if.slave         host,
  boreal_classifier_cfg_sequencer_if.master        cfg,
  input  logic                                     commit,
  input  logic                                     in_valid,
  input  logic                                     drop_clr,
  output logic                                     out_valid,
  output logic                                     hold,
  output logic                                     busy,
  output logic                                     done,
  output logic [DROP_W-1:0]                        drop_cnt
);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t                state, state_n;
  logic [CFG_DATA_W-1:0] shadow [NREG];
  logic [CFG_DATA_W-1:0] shadow_n [NREG];
  logic [CFG_DATA_W-1:0] staging [NREG];
  logic [CFG_ADDR_W-1:0] idx, idx_n;
  logic [QW-1:0]         quiet_cnt;
  logic [WW-1:0]         wait_cnt;
  logic                  pending, snap, go;

  assign go        = (~in_valid && quiet_cnt == QW'(QUIET_CYCLES - 1)) || wait_cnt == WW'(TIMEOUT - 1);
  assign busy      = state != IDLE;
  assign out_valid = in_valid & ~hold;

  // shadow contents after this cycle's host write, so a same-cycle commit sees it
  always_comb begin
    for (int i = 0; i < NREG; i++)
      shadow_n[i] = (host.we && host.addr == CFG_ADDR_W'(i)) ? host.din : shadow[i];
  end

  // next state, write index and snapshot request
  always_comb begin
    state_n = state;
    idx_n   = idx;
    snap    = 1'b0;
    case (state)
      IDLE: begin
        state_n = commit ? WAIT_QUIET : IDLE;
        snap    = commit;
      end
      WAIT_QUIET: begin
        state_n = go ? WRITE : WAIT_QUIET;
        idx_n   = '0;
      end
      WRITE: begin
        state_n = idx == CFG_ADDR_W'(NREG - 1) ? RELEASE : WRITE;
        idx_n   = idx + 1'b1;
      end
      RELEASE: begin
        state_n = (pending || commit) ? WAIT_QUIET : IDLE;
        snap    = pending || commit;
      end
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // quiet/timeout counters and merged pending commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quiet_cnt <= '0;
      wait_cnt  <= '0;
      pending   <= 1'b0;
    end else begin
      quiet_cnt <= state == WAIT_QUIET ? (in_valid ? '0 : quiet_cnt + 1'b1) : '0;
      wait_cnt  <= state == WAIT_QUIET ? wait_cnt + 1'b1 : '0;
      pending   <= (state == WAIT_QUIET || state == WRITE) && (pending || commit);
    end
  end

  // registered classifier bus, driven from the next state so the first write lands on WRITE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg.we   <= 1'b0;
      cfg.addr <= '0;
      cfg.din  <= '0;
      hold     <= 1'b0;
      done     <= 1'b0;
    end else begin
      cfg.we   <= state_n == WRITE;
      cfg.addr <= state_n == WRITE ? idx_n : '0;
      cfg.din  <= state_n == WRITE ? staging[idx_n] : '0;
      hold     <= state_n == WRITE || state_n == RELEASE;
      done     <= state_n == RELEASE;
    end
  end

  // host shadow bank and commit snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        shadow[i]  <= reg_rst(i);
        staging[i] <= reg_rst(i);
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        shadow[i]  <= shadow_n[i];
        staging[i] <= snap ? shadow_n[i] : staging[i];
      end
    end
  end

  // saturating count of samples dropped while held; clear takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else if (drop_clr) drop_cnt <= '0;
    else if (in_valid && hold && ~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
  end
endmodule

// File: tb/tb_boreal_classifier_cfg_sequencer.sv
// tb_boreal_classifier_cfg_sequencer: directed vectors and corner sequences for the config sequencer
module tb_boreal_classifier_cfg_sequencer;
  logic clk = 0, rst = 1, commit = 0, in_valid = 0, drop_clr = 0;
  logic out_valid, hold, busy, done;
  logic [7:0] drop_cnt;
  int pass = 0, total = 0;

  boreal_classifier_cfg_sequencer_if host_bus();
  boreal_classifier_cfg_sequencer_if cfg_bus();

  boreal_classifier_cfg_sequencer dut (
    .clk(clk), .rst(rst), .host(host_bus), .cfg(cfg_bus), .commit(commit),
    .in_valid(in_valid), .drop_clr(drop_clr), .out_valid(out_valid), .hold(hold),
    .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hwe; logic [2:0] ha; logic [15:0] hd; logic cm, iv;
    logic ewe; logic [2:0] ea; logic [15:0] ed; logic eh, edn, eb, eov;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic hwe, input logic [2:0] ha, input logic [15:0] hd, input logic cm, iv,
                     input logic ewe, input logic [2:0] ea, input logic [15:0] ed, input logic eh, edn, eb, eov);
    vt.push_back('{hwe, ha, hd, cm, iv, ewe, ea, ed, eh, edn, eb, eov});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    logic seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (done) seen = 1;
    end
    chk(nm, {31'd0, seen}, 1);
    tick();
  endtask

  initial begin
    logic [2:0] qa[$];
    logic [15:0] qd[$];
    int pat[7] = '{1, 0, 1, 0, 1, 0, 0};
    int first, dn, st;
    logic viol, hit;
    host_bus.we = 0; host_bus.addr = 0; host_bus.din = 0;
    #2;
    chk("rst_state", {cfg_bus.we, hold, busy, done}, 0);
    chk("rst_cfg", {13'd0, cfg_bus.addr, cfg_bus.din}, 0);
    chk("rst_drop", {24'd0, drop_cnt}, 0);
    @(negedge clk) rst = 0;

    // reset commit: zeros then bias reset value
    add(0, 0, 0, 1, 0,  0, 0, 16'h0000, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,  1, 0, 16'h0000, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  1, 1, 16'h0000, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  1, 2, 16'h0000, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  1, 3, 16'h0000, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  1, 4, 16'hC000, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 16'h0000, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 0, 0);
    // host writes, ignored out-of-range addr, same-cycle bypass on commit
    add(1, 1, 16'h0123, 0, 0,  0, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 4, 16'hF000, 0, 0,  0, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 7, 16'hABCD, 0, 0,  0, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 2, 16'h0456, 1, 0,  0, 0, 16'h0000, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,  1, 0, 16'h0000, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  1, 1, 16'h0123, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  1, 2, 16'h0456, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  1, 3, 16'h0000, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  1, 4, 16'hF000, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 16'h0000, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  0, 0, 16'h0000, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 0, 0);
    foreach (vt[i]) begin
      @(negedge clk);
      host_bus.we = vt[i].hwe; host_bus.addr = vt[i].ha; host_bus.din = vt[i].hd;
      commit = vt[i].cm; in_valid = vt[i].iv;
      tick();
      chk($sformatf("vec%0d", i),
          {7'd0, cfg_bus.we, cfg_bus.addr, cfg_bus.din, hold, done, busy, out_valid},
          {7'd0, vt[i].ewe, vt[i].ea, vt[i].ed, vt[i].eh, vt[i].edn, vt[i].eb, vt[i].eov});
    end
    @(negedge clk) host_bus.we = 0; commit = 0; in_valid = 0;

    // toggling in_valid: start only after two consecutive quiet cycles
    @(negedge clk) commit = 1;
    tick();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk) commit = 0; in_valid = pat[k][0];
      tick();
      chk($sformatf("t3_we%0d", k), {31'd0, cfg_bus.we}, {31'd0, k == 6});
    end
    @(negedge clk) in_valid = 0;
    wait_done("t3_done");

    // in_valid held high: forced start by timeout, six dropped samples
    @(negedge clk) drop_clr = 1;
    tick();
    chk("t4_clr0", {24'd0, drop_cnt}, 0);
    @(negedge clk) drop_clr = 0; commit = 1; in_valid = 1;
    tick();
    @(negedge clk) commit = 0;
    first = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (cfg_bus.we) begin first = k; break; end
    end
    chk("t4_forced", first, 64);
    viol = 0;
    for (int n = 0; n < 20 && busy; n++) begin
      if (hold && out_valid) viol = 1;
      tick();
    end
    chk("t4_ov_held", {31'd0, viol}, 0);
    chk("t4_drop", {24'd0, drop_cnt}, 6);
    chk("t4_ov_idle", {31'd0, out_valid}, 1);
    @(negedge clk) drop_clr = 1;
    tick();
    chk("t4_clr", {24'd0, drop_cnt}, 0);
    @(negedge clk) drop_clr = 0; in_valid = 0;

    // host write during WRITE plus commit while busy: old value first, then re-run
    @(negedge clk) host_bus.we = 1; host_bus.addr = 0; host_bus.din = 16'h1111;
    @(negedge clk) host_bus.we = 0; commit = 1;
    @(negedge clk) commit = 0;
    dn = 0; st = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (cfg_bus.we) begin qa.push_back(cfg_bus.addr); qd.push_back(cfg_bus.din); end
      if (done) dn++;
      if (cfg_bus.we && st == 0) st = 1;
      @(negedge clk);
      host_bus.we = st == 1; host_bus.addr = 0; host_bus.din = 16'h7FFF; commit = st == 2;
      if (st == 1 || st == 2) st++;
    end
    chk("t5_nwe", qa.size(), 10);
    chk("t5_dones", dn, 2);
    chk("t5_old_w0", {13'd0, qa[0], qd[0]}, {13'd0, 3'd0, 16'h1111});
    chk("t5_new_w0", {13'd0, qa[5], qd[5]}, {13'd0, 3'd0, 16'h7FFF});
    chk("t5_bias", {13'd0, qa[9], qd[9]}, {13'd0, 3'd4, 16'hF000});

    // reset mid-WRITE aborts the sequence; next commit starts over from reset values
    @(negedge clk) commit = 1;
    @(negedge clk) commit = 0;
    hit = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (cfg_bus.we && cfg_bus.addr == 2) begin hit = 1; break; end
    end
    chk("t6_reach2", {31'd0, hit}, 1);
    @(negedge clk) rst = 1;
    #1;
    chk("t6_rst_ctl", {cfg_bus.we, hold, busy, done}, 0);
    chk("t6_rst_bus", {13'd0, cfg_bus.addr, cfg_bus.din, drop_cnt != 0}, 0);
    @(negedge clk) rst = 0;
    viol = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (cfg_bus.we || busy) viol = 1;
    end
    chk("t6_quiet", {31'd0, viol}, 0);
    qa.delete(); qd.delete();
    @(negedge clk) commit = 1;
    @(negedge clk) commit = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (cfg_bus.we) begin qa.push_back(cfg_bus.addr); qd.push_back(cfg_bus.din); end
    end
    chk("t6_nwe", qa.size(), 5);
    chk("t6_first", {13'd0, qa[0], qd[0]}, 0);
    chk("t6_bias", {13'd0, qa[4], qd[4]}, {13'd0, 3'd4, 16'hC000});

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
